fifo_stream_reader: RTL and testbench

//  Read-side drain engine for the team's FIFOs; sits in the read clock domain.

---
 rtl/fifo_pkg.sv | 6 +
 rtl/fifo_skid_buf.sv | 46 ++++
 rtl/fifo_stream_reader.sv | 56 +++++
 tb/tb_fifo_stream_reader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types: default word width, word and occupancy typedefs.
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  typedef logic [DATA_WIDTH_DEF-1:0] fifo_word_t;
  typedef logic [1:0]                occ_t;
endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register holding buffer; entry 0 is always the head.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output occ_t                  occ
);
  logic [1:0][DATA_WIDTH-1:0] mem;

  // Caller guarantees no pop at occ=0 and no push-only at occ=2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem <= '0;
      occ <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          mem[occ[0]] <= push_data;
          occ         <= occ + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            mem[0] <= mem[1];
            mem[1] <= push_data;
          end else begin
            mem[0] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = mem[0];
endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read port to valid/ready stream with 2-word prefetch.
// Optional pop counter on word_count when FIFO_READER_COUNT_EN is defined.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
`ifdef FIFO_READER_COUNT_EN
  ,parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  read_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_READER_COUNT_EN
  ,output logic [CNT_WIDTH-1:0] word_count
`endif
);
  occ_t       occ;
  logic       inflight;
  logic       pop;
  logic [2:0] credit;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;

  // Buffer slots plus the word already requested; a pop frees a slot this cycle.
  assign credit  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign read_en = !reset && !fifo_empty && (credit < 3'd2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= read_en;
  end

  fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data (fifo_data),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

`ifdef FIFO_READER_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)    word_count <= '0;
    else if (pop) word_count <= word_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: FIFO model feeds the reader, monitor compares popped words.
module tb_fifo_stream_reader;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          read_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO_READER_COUNT_EN
  localparam int CW = 4;
  logic [CW-1:0] word_count;
`endif

  always #5 clock = ~clock;

  fifo_stream_reader #(
    .DATA_WIDTH(DW)
`ifdef FIFO_READER_COUNT_EN
    ,.CNT_WIDTH(CW)
`endif
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .read_en    (read_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_READER_COUNT_EN
    ,.word_count(word_count)
`endif
  );

  logic [DW-1:0] src_mem [0:4095];
  logic [11:0]   wr_ptr = '0;
  logic [11:0]   rd_ptr;
  logic [DW-1:0] exp_q[$];
  int            errs = 0;
  int            checks = 0;
  int            re_cnt = 0;
  int            pop_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // FIFO model: data one cycle after read_en, registered empty flag.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr     <= wr_ptr;
      fifo_data  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (read_en) fifo_data <= src_mem[rd_ptr];
      rd_ptr     <= rd_ptr + 12'(read_en);
      fifo_empty <= ((rd_ptr + 12'(read_en)) == wr_ptr);
    end
  end

  // Monitor: scoreboard pops, stability under backpressure, read-while-empty.
  logic          hold;
  logic [DW-1:0] hold_data;
  int            mon_wc;
  initial begin
    hold = 1'b0;
    hold_data = '0;
    mon_wc = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold = 1'b0;
        mon_wc = 0;
      end else begin
        if (read_en) re_cnt++;
        chk("read_while_empty", {31'd0, read_en & fifo_empty}, 32'd0);
        if (hold) begin
          chk("hold_valid", {31'd0, m_valid}, 32'd1);
          chk("hold_data", {24'd0, m_data}, {24'd0, hold_data});
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) chk("unexpected_pop", {24'd0, m_data}, 32'hFFFF_FFFF);
          else chk("sb_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
`ifdef FIFO_READER_COUNT_EN
          chk("wc_run", {28'd0, word_count}, 32'(mon_wc % 16));
          mon_wc++;
`endif
          pop_cnt++;
        end
        hold = m_valid && !m_ready;
        hold_data = m_data;
      end
    end
  end

  task automatic push(input logic [DW-1:0] w);
    src_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 12'd1;
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input int n);
    int k;
    for (k = 0; k < n; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !m_valid) break;
    end
    chk("drain_timeout", {31'd0, k < n}, 32'd1);
  endtask

  task automatic wait_read(input int n);
    int k;
    for (k = 0; k < n; k++) begin
      @(negedge clock);
      if (read_en) break;
    end
    chk("read_en_timeout", {31'd0, k < n}, 32'd1);
  endtask

  initial begin
    int c0;
    int run;
    logic [5:0] exp_re;
    logic [5:0] exp_mv;
    reset = 1'b1;
    m_ready = 1'b0;
    @(negedge clock);
    chk("rst_read_en", {31'd0, read_en}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    repeat (2) step();
    reset = 1'b0;

    // Empty FIFO: nothing requested, nothing presented.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("t1_read_en", {31'd0, read_en}, 32'd0);
      chk("t1_m_valid", {31'd0, m_valid}, 32'd0);
    end

    // Three words at full rate: exact read_en / m_valid timeline.
    step();
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    wait_read(10);
    exp_re = 6'b000111;
    exp_mv = 6'b011100;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clock);
      chk("t2_read_en", {31'd0, read_en}, {31'd0, exp_re[i]});
      chk("t2_m_valid", {31'd0, m_valid}, {31'd0, exp_mv[i]});
    end
    wait_drain(20);

    // Backpressure: exactly two prefetches, head held; then gapless drain.
    step();
    m_ready = 1'b0;
    c0 = re_cnt;
    for (int i = 1; i <= 5; i++) push(8'(8'h50 + i));
    repeat (10) @(negedge clock);
    chk("t3_reads", 32'(re_cnt - c0), 32'd2);
    chk("t3_m_valid", {31'd0, m_valid}, 32'd1);
    chk("t3_head", {24'd0, m_data}, 32'h51);
    step();
    m_ready = 1'b1;
    run = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (m_valid) run++;
      else break;
    end
    chk("t3_gapless", 32'(run), 32'd5);
    chk("t3_empty", 32'(exp_q.size()), 32'd0);

    // Random backpressure over 1000 words.
    for (int i = 0; i < 1000; i++) push(8'(i * 7 + 3));
    for (int k = 0; k < 6000 && exp_q.size() != 0; k++) begin
      step();
      m_ready = 1'($urandom_range(0, 1));
    end
    step();
    m_ready = 1'b1;
    wait_drain(20);

    // Reset with a buffered word and one in flight: all discarded.
    step();
    m_ready = 1'b0;
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    wait_read(10);
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_async_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_async_read_en", {31'd0, read_en}, 32'd0);
    exp_q.delete();
    repeat (2) step();
    reset = 1'b0;
    c0 = pop_cnt;
    push(8'hA1); push(8'hA2);
    m_ready = 1'b1;
    wait_drain(20);
    chk("t5_pops", 32'(pop_cnt - c0), 32'd2);

`ifdef FIFO_READER_COUNT_EN
    step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 18; i++) push(8'(8'hC0 + i));
    wait_drain(60);
    chk("t6_wrap", {28'd0, word_count}, 32'd2);
    step();
    m_ready = 1'b0;
    push(8'hE1); push(8'hE2);
    repeat (8) @(negedge clock);
    chk("t6_hold", {28'd0, word_count}, 32'd2);
    step();
    m_ready = 1'b1;
    wait_drain(20);
    chk("t6_final", {28'd0, word_count}, 32'd4);
`endif

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
